ofs_fim_pcie_tag_tracker: RTL and testbench
===========================================

// Module: ofs_fim_pcie_tag_tracker
// PURPOSE
//  Allocates PCIe tags for outgoing non-posted read requests on the FIM TX path and reserves completion credit (DW) per request.
//  Tracks outstanding tags and releases tag and credit on the final completion or on completion timeout.
//  Flags err_cpl_timeout, err_unexp_cpl and err_cpl_status toward the t_tlp_err aggregation.
//  Sits between the TX request arbiter (upstream) and the RX completion decoder (downstream).
// PARAMETERS
//  MAX_TAGS      128        tag space (PCIE_EP_MAX_TAGS); need not be a power of 2
//  TAG_WIDTH     7          $clog2(MAX_TAGS)
//  CREDIT_DW     10000      completion buffer size in DW (PCIE_CPL_CREDIT*4)
//  CREDIT_WIDTH  14         $clog2(CREDIT_DW)
//  LEN_WIDTH     11         request/completion length width in DW (1..1024)
//  TIMEOUT       12500000   completion timeout in clk cycles; sim builds use 256
//  TIME_WIDTH    26         timestamp width
// PORTS
//  clk             in   1             single clock
//  rst_n           in   1             synchronous reset, active-low
//  alloc_req       in   1             request for a tag (level; held until alloc_gnt)
//  alloc_len_dw    in   LEN_WIDTH     read length in DW; stable while alloc_req is high
//  alloc_gnt       out  1             combinational grant; tag consumed this cycle
//  alloc_tag       out  TAG_WIDTH     granted tag; valid with alloc_gnt
//  cpl_valid       in   1             completion header observed (one per cycle max)
//  cpl_tag         in   TAG_WIDTH     completion tag
//  cpl_last        in   1             final completion of the request
//  cpl_status_ok   in   1             completion status == SC
//  err_cpl_timeout out  1             1-cycle pulse, registered
//  err_to_tag      out  TAG_WIDTH     tag that timed out; valid with err_cpl_timeout
//  err_unexp_cpl   out  1             1-cycle pulse, registered
//  err_cpl_status  out  1             1-cycle pulse, registered
//  err_cpl_tag     out  TAG_WIDTH     tag of unexp/status error
//  credit_avail    out  CREDIT_WIDTH+1  unreserved completion credit, registered
//  tags_busy       out  TAG_WIDTH+1   count of outstanding tags, registered
// BEHAVIOUR
//  Reset: all tags free; credit_avail=CREDIT_DW; tags_busy=0; alloc/scan pointers=0; timestamp=0; all err_* and err tags 0; alloc_gnt held 0.
//   Reset mid-operation discards outstanding tags silently (no errors).
//  State per tag: busy bit, reserved length (LEN_WIDTH), start timestamp (TIME_WIDTH).
//  Timestamp: free-running TIME_WIDTH counter; wraps; age = (now - start) mod 2^TIME_WIDTH.
//  Allocation: alloc_gnt = rst_n & alloc_req & !busy[aptr] & (credit_avail >= alloc_len_dw); alloc_tag = aptr.
//   On grant: busy set, len/start stored, credit reserved, aptr advances next cycle.
//   If busy[aptr]: aptr advances every cycle (scanning), independent of alloc_req.
//   aptr wraps MAX_TAGS-1 -> 0 (non-power-of-2 safe). Blocked on credit: aptr holds, no grant.
//  Completion, cpl_valid:
//   tag free -> err_unexp_cpl pulse next cycle, err_cpl_tag=cpl_tag; no state change.
//   tag busy & !cpl_status_ok -> err_cpl_status pulse; processing otherwise normal.
//   tag busy & cpl_last -> tag freed, stored len returned to credit.
//   Credit is returned only at release, never per partial completion.
//  Timeout scan: sptr visits one tag per cycle, wraps like aptr.
//   busy & age >= TIMEOUT -> tag freed, credit returned, err_cpl_timeout pulse with err_to_tag.
//   Detection latency <= TIMEOUT + MAX_TAGS cycles after grant.
//  Simultaneous events:
//   cpl_last and timeout on the same tag: completion wins, no timeout error.
//   Grant, cpl release and timeout release in one cycle: credit_avail += rel_cpl + rel_to - granted.
//   tags_busy changes by the same net count.
//   Grant cannot target a tag being released that cycle (it must be free at aptr).
//   Unexpected cpl and timeout in one cycle: both pulses assert, each with its own tag output.
//  Invariants:
//   credit_avail + sum(reserved len) == CREDIT_DW; credit_avail never exceeds CREDIT_DW or underflows.
// TESTING
//  Reset, alloc_req len=16 x3 -> gnt tags 0,1,2 on consecutive cycles; credit_avail 9952; tags_busy 3.
//  cpl tag1 cpl_last=0 then cpl_last=1 -> credit unchanged until last, then 9968; tags_busy 2; tag1 reusable.
//  cpl_valid tag 50 (free) -> err_unexp_cpl 1 cycle, err_cpl_tag=50; credit, tags_busy unchanged.
//  TIMEOUT=256, grant tag0, no cpl -> err_cpl_timeout within 256..384 cycles, err_to_tag=0; credit back to 10000.
//  Request len=1024 x9 -> gnt x9 (credit 784); 10th len=1024 held off until a cpl_last frees credit.
//  128 grants, no cpls -> alloc_gnt stays 0; cpl_last tag 5 -> next grant is tag 5; reset mid-burst -> all free, no err pulses.

Source files
------------

// File: rtl/ofs_fim_pcie_tag_tracker.sv
// ofs_fim_pcie_tag_tracker
//   Hands out PCIe tags to outgoing non-posted reads and reserves completion
//   buffer credit (in DW) for each one. Tracks outstanding tags and releases
//   tag plus credit on the final completion or when a tag ages past TIMEOUT.
//   Error pulses feed the TLP error aggregation.
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   alloc_req/alloc_len_dw     tag request from the TX arbiter (level, held)
//   alloc_gnt/alloc_tag        combinational grant and granted tag
//   cpl_valid/cpl_tag/...      completion header info from the RX decoder
//   err_cpl_timeout/err_to_tag timeout pulse and the tag that expired
//   err_unexp_cpl/err_cpl_status/err_cpl_tag  completion error pulses and tag
//   credit_avail               unreserved completion credit (DW)
//   tags_busy                  number of outstanding tags
module ofs_fim_pcie_tag_tracker #(
  parameter int MAX_TAGS     = 128,
  parameter int TAG_WIDTH    = 7,
  parameter int CREDIT_DW    = 10000,
  parameter int CREDIT_WIDTH = 14,
  parameter int LEN_WIDTH    = 11,
  parameter int TIMEOUT      = 12500000,
  parameter int TIME_WIDTH   = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_req,
  input  logic [LEN_WIDTH-1:0]    alloc_len_dw,
  output logic                    alloc_gnt,
  output logic [TAG_WIDTH-1:0]    alloc_tag,
  input  logic                    cpl_valid,
  input  logic [TAG_WIDTH-1:0]    cpl_tag,
  input  logic                    cpl_last,
  input  logic                    cpl_status_ok,
  output logic                    err_cpl_timeout,
  output logic [TAG_WIDTH-1:0]    err_to_tag,
  output logic                    err_unexp_cpl,
  output logic                    err_cpl_status,
  output logic [TAG_WIDTH-1:0]    err_cpl_tag,
  output logic [CREDIT_WIDTH:0]   credit_avail,
  output logic [TAG_WIDTH:0]      tags_busy
);

  // Per-tag state is sized to the full index space so any cpl_tag value
  // indexes safely; entries at or above MAX_TAGS are never allocated and so
  // always read as free.
  localparam int TAG_SPACE = 1 << TAG_WIDTH;
  localparam int CW        = CREDIT_WIDTH + 1;
  localparam int BW        = TAG_WIDTH + 1;
  localparam logic [TAG_WIDTH-1:0]  LAST_TAG    = TAG_WIDTH'(MAX_TAGS - 1);
  localparam logic [TIME_WIDTH-1:0] TIMEOUT_T   = TIME_WIDTH'(TIMEOUT);
  localparam logic [CW-1:0]         CREDIT_INIT = CW'(CREDIT_DW);

  logic [TAG_SPACE-1:0]  busy_q, busy_d;
  logic [LEN_WIDTH-1:0]  len_q   [TAG_SPACE];
  logic [TIME_WIDTH-1:0] start_q [TAG_SPACE];

  logic [TAG_WIDTH-1:0]  aptr_q, aptr_d;
  logic [TAG_WIDTH-1:0]  sptr_q, sptr_d;
  logic [TIME_WIDTH-1:0] now_q;
  logic [CW-1:0]         credit_q, credit_d;
  logic [BW-1:0]         busy_cnt_q, busy_cnt_d;

  logic                  err_to_q, err_unexp_q, err_status_q;
  logic [TAG_WIDTH-1:0]  err_to_tag_q, err_cpl_tag_q;

  logic                  aptr_busy;
  logic                  cpl_hit;
  logic                  rel_cpl;
  logic                  rel_to;
  logic [TIME_WIDTH-1:0] age;
  logic                  unexp_d;
  logic                  status_d;
  logic [CW-1:0]         gnt_len, rel_cpl_len, rel_to_len;

  // Allocation
  assign aptr_busy = busy_q[aptr_q];
  assign alloc_gnt = rst_n & alloc_req & ~aptr_busy
                   & (credit_q >= CW'(alloc_len_dw));
  assign alloc_tag = aptr_q;

  // Completion handling
  assign cpl_hit  = cpl_valid & busy_q[cpl_tag];
  assign rel_cpl  = cpl_hit & cpl_last;
  assign unexp_d  = cpl_valid & ~busy_q[cpl_tag];
  assign status_d = cpl_hit & ~cpl_status_ok;

  // Timeout scan; a final completion on the scanned tag takes precedence
  assign age    = now_q - start_q[sptr_q];
  assign rel_to = busy_q[sptr_q] & (age >= TIMEOUT_T)
                & ~(rel_cpl & (cpl_tag == sptr_q));

  assign gnt_len     = alloc_gnt ? CW'(alloc_len_dw)    : '0;
  assign rel_cpl_len = rel_cpl   ? CW'(len_q[cpl_tag])  : '0;
  assign rel_to_len  = rel_to    ? CW'(len_q[sptr_q])   : '0;

  always_comb begin
    busy_d = busy_q;
    // A grant only targets a free tag, so it never collides with a release.
    if (alloc_gnt) busy_d[aptr_q] = 1'b1;
    if (rel_cpl)   busy_d[cpl_tag] = 1'b0;
    if (rel_to)    busy_d[sptr_q]  = 1'b0;
  end

  always_comb begin
    credit_d   = credit_q + rel_cpl_len + rel_to_len - gnt_len;
    busy_cnt_d = busy_cnt_q + BW'(alloc_gnt) - BW'(rel_cpl) - BW'(rel_to);
    // Pointer moves past a granted tag and keeps scanning over busy tags;
    // it holds on a free tag while waiting for credit or a request.
    if (alloc_gnt || aptr_busy)
      aptr_d = (aptr_q == LAST_TAG) ? '0 : aptr_q + TAG_WIDTH'(1);
    else
      aptr_d = aptr_q;
    sptr_d = (sptr_q == LAST_TAG) ? '0 : sptr_q + TAG_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q        <= '0;
      aptr_q        <= '0;
      sptr_q        <= '0;
      now_q         <= '0;
      credit_q      <= CREDIT_INIT;
      busy_cnt_q    <= '0;
      err_to_q      <= 1'b0;
      err_unexp_q   <= 1'b0;
      err_status_q  <= 1'b0;
      err_to_tag_q  <= '0;
      err_cpl_tag_q <= '0;
    end else begin
      busy_q       <= busy_d;
      aptr_q       <= aptr_d;
      sptr_q       <= sptr_d;
      now_q        <= now_q + TIME_WIDTH'(1);
      credit_q     <= credit_d;
      busy_cnt_q   <= busy_cnt_d;
      err_to_q     <= rel_to;
      err_unexp_q  <= unexp_d;
      err_status_q <= status_d;
      if (rel_to)              err_to_tag_q  <= sptr_q;
      if (unexp_d || status_d) err_cpl_tag_q <= cpl_tag;
    end
  end

  // Per-tag payload needs no reset: it is only read while the busy bit is set.
  always_ff @(posedge clk) begin
    if (alloc_gnt) begin
      len_q[aptr_q]   <= alloc_len_dw;
      start_q[aptr_q] <= now_q;
    end
  end

  assign err_cpl_timeout = err_to_q;
  assign err_to_tag      = err_to_tag_q;
  assign err_unexp_cpl   = err_unexp_q;
  assign err_cpl_status  = err_status_q;
  assign err_cpl_tag     = err_cpl_tag_q;
  assign credit_avail    = credit_q;
  assign tags_busy       = busy_cnt_q;

endmodule

// File: tb/tb_ofs_fim_pcie_tag_tracker.sv
// Testbench for ofs_fim_pcie_tag_tracker with TIMEOUT shortened to 256.
module tb_ofs_fim_pcie_tag_tracker;
  localparam int MAX_TAGS     = 128;
  localparam int TAG_WIDTH    = 7;
  localparam int CREDIT_DW    = 10000;
  localparam int CREDIT_WIDTH = 14;
  localparam int LEN_WIDTH    = 11;
  localparam int TIMEOUT      = 256;
  localparam int TIME_WIDTH   = 26;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    alloc_req = 1'b0;
  logic [LEN_WIDTH-1:0]    alloc_len_dw = '0;
  logic                    alloc_gnt;
  logic [TAG_WIDTH-1:0]    alloc_tag;
  logic                    cpl_valid = 1'b0;
  logic [TAG_WIDTH-1:0]    cpl_tag = '0;
  logic                    cpl_last = 1'b0;
  logic                    cpl_status_ok = 1'b1;
  logic                    err_cpl_timeout;
  logic [TAG_WIDTH-1:0]    err_to_tag;
  logic                    err_unexp_cpl;
  logic                    err_cpl_status;
  logic [TAG_WIDTH-1:0]    err_cpl_tag;
  logic [CREDIT_WIDTH:0]   credit_avail;
  logic [TAG_WIDTH:0]      tags_busy;

  ofs_fim_pcie_tag_tracker #(
    .MAX_TAGS(MAX_TAGS), .TAG_WIDTH(TAG_WIDTH), .CREDIT_DW(CREDIT_DW),
    .CREDIT_WIDTH(CREDIT_WIDTH), .LEN_WIDTH(LEN_WIDTH), .TIMEOUT(TIMEOUT),
    .TIME_WIDTH(TIME_WIDTH)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_len_dw(alloc_len_dw),
    .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_last(cpl_last),
    .cpl_status_ok(cpl_status_ok),
    .err_cpl_timeout(err_cpl_timeout), .err_to_tag(err_to_tag),
    .err_unexp_cpl(err_unexp_cpl), .err_cpl_status(err_cpl_status),
    .err_cpl_tag(err_cpl_tag),
    .credit_avail(credit_avail), .tags_busy(tags_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Scoreboard queues and reference model of outstanding tags
  logic [TAG_WIDTH-1:0] exp_tag_q [$];
  logic [TAG_WIDTH-1:0] exp_err_q [$];
  bit mbusy [MAX_TAGS];
  int mlen  [MAX_TAGS];
  int m_credit;
  int m_busy;

  task automatic model_clear();
    for (int t = 0; t < MAX_TAGS; t++) begin
      mbusy[t] = 1'b0;
      mlen[t]  = 0;
    end
    m_credit = CREDIT_DW;
    m_busy   = 0;
    exp_tag_q.delete();
    exp_err_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; alloc_req = 1'b0; cpl_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Holds alloc_req for up to budget cycles; called on a negedge, returns on one.
  task automatic request(input int len, input int budget, input bit expect_gnt,
                         output bit granted, output int gcyc);
    logic [TAG_WIDTH-1:0] exp;
    granted = 1'b0;
    gcyc = 0;
    alloc_req = 1'b1;
    alloc_len_dw = LEN_WIDTH'(len);
    for (int i = 0; i < budget && !granted; i++) begin
      #1;
      if (alloc_gnt === 1'b1) begin
        granted = 1'b1;
        gcyc = cyc;
        checks++;
        if (exp_tag_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got tag %0d, required no grant", alloc_tag);
          exp = alloc_tag;
        end else begin
          exp = exp_tag_q.pop_front();
          if (alloc_tag !== exp) begin
            errors++;
            $display("FAIL grant_tag: got %0d required %0d", alloc_tag, exp);
          end
        end
        mbusy[exp] = 1'b1;
        mlen[exp]  = len;
        m_credit  -= len;
        m_busy++;
      end
      @(negedge clk);
    end
    alloc_req = 1'b0;
    if (!granted) begin
      checks++;
      if (expect_gnt) begin
        errors++;
        $display("FAIL grant_wait: no grant within %0d cycles", budget);
        exp_tag_q.delete();
      end
    end
  endtask

  // One completion beat; called on a negedge, returns on the next one.
  task automatic cpl(input int tag, input bit last, input bit ok);
    cpl_valid = 1'b1;
    cpl_tag = TAG_WIDTH'(tag);
    cpl_last = last;
    cpl_status_ok = ok;
    if (mbusy[tag]) begin
      if (!ok) exp_err_q.push_back(TAG_WIDTH'(tag));
      if (last) begin
        mbusy[tag] = 1'b0;
        m_credit  += mlen[tag];
        m_busy--;
      end
    end else begin
      exp_err_q.push_back(TAG_WIDTH'(tag));
    end
    @(negedge clk);
    cpl_valid = 1'b0; cpl_last = 1'b0; cpl_status_ok = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    alloc_req = 1'b1; alloc_len_dw = 11'd1;
    #1;
    checks++;
    if (alloc_gnt !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: got %0b required 0", alloc_gnt);
    end
    apply_reset();
    checks++;
    if (credit_avail !== 15'd10000) begin
      errors++; $display("FAIL reset_credit: got %0d required 10000", credit_avail);
    end
    checks++;
    if (tags_busy !== 8'd0) begin
      errors++; $display("FAIL reset_busy: got %0d required 0", tags_busy);
    end
    checks++;
    if ({err_cpl_timeout, err_unexp_cpl, err_cpl_status, err_to_tag, err_cpl_tag} !== '0) begin
      errors++;
      $display("FAIL reset_err: got to=%0b unexp=%0b st=%0b to_tag=%0d cpl_tag=%0d required all 0",
               err_cpl_timeout, err_unexp_cpl, err_cpl_status, err_to_tag, err_cpl_tag);
    end
  endtask

  task automatic test_alloc();
    bit g;
    int c [3];
    for (int i = 0; i < 3; i++) begin
      exp_tag_q.push_back(TAG_WIDTH'(i));
      request(16, 5, 1'b1, g, c[i]);
    end
    checks++;
    if (c[1] - c[0] != 1 || c[2] - c[1] != 1) begin
      errors++; $display("FAIL alloc_consecutive: grant cycles %0d %0d %0d, required consecutive", c[0], c[1], c[2]);
    end
    checks++;
    if (credit_avail !== 15'(m_credit) || m_credit != 9952) begin
      errors++; $display("FAIL alloc_credit: got %0d required 9952", credit_avail);
    end
    checks++;
    if (tags_busy !== 8'd3) begin
      errors++; $display("FAIL alloc_busy: got %0d required 3", tags_busy);
    end
  endtask

  task automatic test_partial_cpl();
    cpl(1, 1'b0, 1'b1);
    checks++;
    if (credit_avail !== 15'd9952 || tags_busy !== 8'd3) begin
      errors++; $display("FAIL partial_cpl: got credit=%0d busy=%0d required 9952/3", credit_avail, tags_busy);
    end
    cpl(1, 1'b1, 1'b1);
    checks++;
    if (credit_avail !== 15'd9968 || tags_busy !== 8'd2) begin
      errors++; $display("FAIL last_cpl: got credit=%0d busy=%0d required 9968/2", credit_avail, tags_busy);
    end
    checks++;
    if (err_unexp_cpl !== 1'b0 || err_cpl_status !== 1'b0) begin
      errors++; $display("FAIL cpl_noerr: got unexp=%0b status=%0b required 0/0", err_unexp_cpl, err_cpl_status);
    end
    cpl(0, 1'b1, 1'b1);
    cpl(2, 1'b1, 1'b1);
    checks++;
    if (credit_avail !== 15'(m_credit) || tags_busy !== 8'(m_busy)) begin
      errors++; $display("FAIL cpl_drain: got credit=%0d busy=%0d required %0d/%0d", credit_avail, tags_busy, m_credit, m_busy);
    end
  endtask

  task automatic test_unexp_cpl();
    logic [TAG_WIDTH-1:0] exp;
    cpl(50, 1'b1, 1'b1);
    exp = exp_err_q.pop_front();
    checks++;
    if (err_unexp_cpl !== 1'b1 || err_cpl_tag !== exp) begin
      errors++; $display("FAIL unexp_pulse: got pulse=%0b tag=%0d required 1/%0d", err_unexp_cpl, err_cpl_tag, exp);
    end
    checks++;
    if (credit_avail !== 15'(m_credit) || tags_busy !== 8'(m_busy)) begin
      errors++; $display("FAIL unexp_state: got credit=%0d busy=%0d required %0d/%0d", credit_avail, tags_busy, m_credit, m_busy);
    end
    @(negedge clk);
    checks++;
    if (err_unexp_cpl !== 1'b0) begin
      errors++; $display("FAIL unexp_width: got %0b one cycle later, required 0", err_unexp_cpl);
    end
  endtask

  task automatic test_status_err();
    logic [TAG_WIDTH-1:0] exp;
    bit g; int c;
    exp_tag_q.push_back(7'd3);
    request(16, 5, 1'b1, g, c);
    cpl(3, 1'b1, 1'b0);
    exp = exp_err_q.pop_front();
    checks++;
    if (err_cpl_status !== 1'b1 || err_unexp_cpl !== 1'b0 || err_cpl_tag !== exp) begin
      errors++; $display("FAIL status_pulse: got st=%0b unexp=%0b tag=%0d required 1/0/%0d",
                         err_cpl_status, err_unexp_cpl, err_cpl_tag, exp);
    end
    checks++;
    if (credit_avail !== 15'(m_credit) || tags_busy !== 8'(m_busy)) begin
      errors++; $display("FAIL status_release: got credit=%0d busy=%0d required %0d/%0d", credit_avail, tags_busy, m_credit, m_busy);
    end
  endtask

  task automatic test_back_to_back();
    bit g; int c;
    logic [TAG_WIDTH-1:0] exp;
    apply_reset();
    exp_tag_q.push_back(7'd0); request(100, 5, 1'b1, g, c);
    exp_tag_q.push_back(7'd1); request(200, 5, 1'b1, g, c);
    // grant of tag 2 and final completion of tag 0 in the same cycle
    alloc_req = 1'b1; alloc_len_dw = 11'd50;
    cpl_valid = 1'b1; cpl_tag = 7'd0; cpl_last = 1'b1; cpl_status_ok = 1'b1;
    exp_tag_q.push_back(7'd2);
    #1;
    exp = exp_tag_q.pop_front();
    checks++;
    if (alloc_gnt !== 1'b1 || alloc_tag !== exp) begin
      errors++; $display("FAIL b2b_gnt: got gnt=%0b tag=%0d required 1/%0d", alloc_gnt, alloc_tag, exp);
    end
    mbusy[2] = 1'b1; mlen[2] = 50; m_credit -= 50; m_busy++;
    mbusy[0] = 1'b0; m_credit += mlen[0]; m_busy--;
    @(negedge clk);
    alloc_req = 1'b0; cpl_valid = 1'b0; cpl_last = 1'b0;
    checks++;
    if (credit_avail !== 15'(m_credit) || m_credit != 9750 || tags_busy !== 8'd2) begin
      errors++; $display("FAIL b2b_credit: got credit=%0d busy=%0d required 9750/2", credit_avail, tags_busy);
    end
    cpl(1, 1'b1, 1'b1);
    cpl(2, 1'b1, 1'b1);
  endtask

  task automatic test_credit_block();
    bit g, blocked;
    int c;
    logic [TAG_WIDTH-1:0] exp;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      exp_tag_q.push_back(TAG_WIDTH'(i));
      request(1024, 5, 1'b1, g, c);
    end
    checks++;
    if (credit_avail !== 15'd784 || tags_busy !== 8'd9) begin
      errors++; $display("FAIL credit_9x1024: got credit=%0d busy=%0d required 784/9", credit_avail, tags_busy);
    end
    blocked = 1'b0;
    alloc_req = 1'b1; alloc_len_dw = 11'd1024;
    for (int i = 0; i < 20; i++) begin
      #1; if (alloc_gnt !== 1'b0) blocked = 1'b1;
      @(negedge clk);
    end
    cpl_valid = 1'b1; cpl_tag = 7'd3; cpl_last = 1'b1; cpl_status_ok = 1'b1;
    #1; if (alloc_gnt !== 1'b0) blocked = 1'b1;
    checks++;
    if (blocked) begin
      errors++; $display("FAIL credit_hold: got a grant with 784 DW available, required none");
    end
    mbusy[3] = 1'b0; m_credit += mlen[3]; m_busy--;
    @(negedge clk);
    cpl_valid = 1'b0; cpl_last = 1'b0;
    exp_tag_q.push_back(7'd9);
    #1;
    exp = exp_tag_q.pop_front();
    checks++;
    if (alloc_gnt !== 1'b1 || alloc_tag !== exp) begin
      errors++; $display("FAIL credit_resume: got gnt=%0b tag=%0d required 1/%0d", alloc_gnt, alloc_tag, exp);
    end
    mbusy[9] = 1'b1; mlen[9] = 1024; m_credit -= 1024; m_busy++;
    @(negedge clk);
    alloc_req = 1'b0;
    checks++;
    if (credit_avail !== 15'(m_credit) || tags_busy !== 8'(m_busy)) begin
      errors++; $display("FAIL credit_after: got credit=%0d busy=%0d required %0d/%0d", credit_avail, tags_busy, m_credit, m_busy);
    end
    for (int t = 0; t < 10; t++) if (mbusy[t]) cpl(t, 1'b1, 1'b1);
    checks++;
    if (credit_avail !== 15'd10000 || tags_busy !== 8'd0) begin
      errors++; $display("FAIL credit_drain: got credit=%0d busy=%0d required 10000/0", credit_avail, tags_busy);
    end
  endtask

  task automatic test_timeout();
    bit g, found;
    int c, k;
    apply_reset();
    exp_tag_q.push_back(7'd0);
    request(16, 5, 1'b1, g, c);
    found = 1'b0; k = 0;
    for (int i = 1; i <= 500 && !found; i++) begin
      @(negedge clk);
      if (err_cpl_timeout === 1'b1) begin
        found = 1'b1; k = i;
      end
    end
    checks++;
    if (!found || k < 256 || k > 384) begin
      errors++; $display("FAIL timeout_latency: got pulse=%0b after %0d cycles, required 256..384", found, k);
    end
    checks++;
    if (err_to_tag !== 7'd0) begin
      errors++; $display("FAIL timeout_tag: got %0d required 0", err_to_tag);
    end
    if (found) begin
      mbusy[0] = 1'b0; m_credit += mlen[0]; m_busy--;
    end
    @(negedge clk);
    checks++;
    if (credit_avail !== 15'(m_credit) || m_credit != 10000 || tags_busy !== 8'd0 || err_cpl_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_release: got credit=%0d busy=%0d pulse=%0b required 10000/0/0",
                         credit_avail, tags_busy, err_cpl_timeout);
    end
  endtask

  task automatic test_full_and_reset();
    bit g, consec;
    int c, prev, pulses;
    apply_reset();
    consec = 1'b1; prev = 0;
    for (int t = 0; t < MAX_TAGS; t++) begin
      exp_tag_q.push_back(TAG_WIDTH'(t));
      request(1, 3, 1'b1, g, c);
      if (t > 0 && c - prev != 1) consec = 1'b0;
      prev = c;
    end
    checks++;
    if (!consec) begin
      errors++; $display("FAIL full_consecutive: grants of 128 tags not back-to-back");
    end
    checks++;
    if (tags_busy !== 8'd128 || credit_avail !== 15'(m_credit)) begin
      errors++; $display("FAIL full_state: got busy=%0d credit=%0d required 128/%0d", tags_busy, credit_avail, m_credit);
    end
    request(1, 3, 1'b0, g, c);
    cpl(5, 1'b1, 1'b1);
    exp_tag_q.push_back(7'd5);
    request(1, 10, 1'b1, g, c);
    // reset with a request still pending: everything is dropped silently
    alloc_req = 1'b1; alloc_len_dw = 11'd1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (alloc_gnt !== 1'b0) begin
      errors++; $display("FAIL midreset_gnt: got %0b required 0", alloc_gnt);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (err_cpl_timeout || err_unexp_cpl || err_cpl_status) pulses++;
    end
    rst_n = 1'b1; alloc_req = 1'b0;
    model_clear();
    checks++;
    if (tags_busy !== 8'd0 || credit_avail !== 15'd10000) begin
      errors++; $display("FAIL midreset_state: got busy=%0d credit=%0d required 0/10000", tags_busy, credit_avail);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err_cpl_timeout || err_unexp_cpl || err_cpl_status) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL midreset_err: got %0d error pulses required 0", pulses);
    end
    exp_tag_q.push_back(7'd0);
    request(1, 5, 1'b1, g, c);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_alloc();
    test_partial_cpl();
    test_unexp_cpl();
    test_status_err();
    test_back_to_back();
    test_credit_block();
    test_timeout();
    test_full_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
